mem_arbiter: RTL
================

# mem_arbiter

Shares the single data-memory port between instruction fetch (I side) and the load/store unit (D side). Selects one requester per cycle, forwards it to memory, records the owner of every outstanding read, and returns in-order read responses to the correct requester. Sits between the fetch stage / LSU and the memory model or bus.

## Interface

- AW, 32: address width
- DW, 32: data width
- MAX_OUT, 2: maximum outstanding reads (1..4)
- STARVE_LIMIT, 4: consecutive D grants allowed while I waits
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held with i_addr until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rd_data  out  DW  fetch read data
- d_req  in  1  LSU request; held with fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  LSU address
- d_wr_data  in  DW  store data
- d_gnt  out  1  LSU request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rd_data  out  DW  load data
- m_req, m_we, m_be, m_addr, m_wr_data  out  1/1/DW/8/AW/DW  memory request
- m_gnt  in  1  memory accepts m_req this cycle (may depend on m_req only)
- m_rvalid  in  1  read response, in request order
- m_rd_data  in  DW  read data
- err  out  1  sticky: m_rvalid with no outstanding read

## Operation

- Eligibility: request is a read if from I, or from D with d_we=0. Reads eligible only when registered out_cnt < MAX_OUT (no same-cycle pop bypass). D stores always eligible.
- Selection: D wins if eligible and (starve_cnt < STARVE_LIMIT or I not eligible); otherwise I wins if eligible.
- m_req = winner exists; m_* fields mux from winner; m_we=0, m_be=all-ones for I.
- x_gnt = m_gnt & (winner == x). Non-winner gnt is 0.
- On read grant: push owner (I/D) into owner FIFO; out_cnt++.
- On m_rvalid: pop FIFO head; assert i_rvalid or d_rvalid for that cycle; both rd_data outputs = m_rd_data.
- Simultaneous push and pop: out_cnt unchanged, both take effect.
- m_rvalid with out_cnt == 0: no pop, no rvalid, err set until reset.
- starve_cnt: +1 (saturate at STARVE_LIMIT) on d_gnt while I eligible and waiting; cleared on i_gnt or when i_req=0.
- Stores produce no response and no FIFO entry.

## Timing

- Grant is combinational, same cycle as request (zero latency); one transfer per cycle maximum.
- Response routing is combinational from m_rvalid; earliest response is the cycle after grant.
- Back-to-back grants sustained while m_gnt=1 and FIFO not full.
- Reset: out_cnt=0, FIFO empty, starve_cnt=0, err=0; all gnt/rvalid outputs 0 while rst=1. Responses arriving after reset for pre-reset reads are treated as orphans (err); memory is reset with the arbiter.
- Requester dropping req before gnt is legal; no state changes.

## Structure

- Shared package: mem_owner_t enum {OWN_I, OWN_D}.
- Sub-module owner_fifo: MAX_OUT-deep, 1-bit-wide (mem_owner_t) register FIFO with push, pop, count, full, empty; wrap-around pointers.
- Top: selection logic, starve counter, err flag.

## Test plan

- I only, i_addr=0x100, m_gnt=1, memory returns 0xDEADBEEF next cycle -> i_gnt in cycle 0, i_rvalid=1, i_rd_data=0xDEADBEEF in cycle 1, d_rvalid=0.
- I and D loads same cycle -> d_gnt first; next cycle i_gnt; responses route D then I in order.
- D requests every cycle, I waiting, STARVE_LIMIT=4 -> 4 d_gnt then 1 i_gnt, pattern repeats.
- MAX_OUT=2, memory withholds m_rvalid -> 2 reads granted, third read stalls, D store still granted; one m_rvalid -> stalled read granted next cycle.
- m_gnt=0 for 3 cycles with d_req held -> no gnt, no FIFO push; grant when m_gnt=1.
- m_rvalid with empty FIFO -> err=1, held; rst for 1 cycle -> err=0, out_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory-port arbiter.
package mem_arbiter_pkg;

    // Which requester owns an outstanding read.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_t;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_MAX_OUT      = 2;
    localparam int DEF_STARVE_LIMIT = 4;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, LSU-side and memory-side signals of the arbiter.
//
// Handshake rules: a requester raises x_req with its fields and holds them
// stable until x_gnt is seen high in the same cycle; dropping x_req earlier
// is allowed and has no effect. On the memory side a transfer happens in any
// cycle with m_req & m_gnt. Read responses carry no backpressure: x_rvalid
// is a one-cycle pulse, and memory returns m_rvalid strictly in request order.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch (I) side
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rd_data;

    // LSU (D) side
    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wr_data;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rd_data;

    // Memory side
    logic            m_req;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wr_data;
    logic            m_gnt;
    logic            m_rvalid;
    logic [DW-1:0]   m_rd_data;

    // Sticky orphan-response flag
    logic            err;

    // Arbiter view
    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rd_data,
        input  d_req, d_we, d_be, d_addr, d_wr_data,
        output d_gnt, d_rvalid, d_rd_data,
        output m_req, m_we, m_be, m_addr, m_wr_data,
        input  m_gnt, m_rvalid, m_rd_data,
        output err
    );

    // Environment view (requesters plus memory)
    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rd_data,
        output d_req, d_we, d_be, d_addr, d_wr_data,
        input  d_gnt, d_rvalid, d_rd_data,
        input  m_req, m_we, m_be, m_addr, m_wr_data,
        output m_gnt, m_rvalid, m_rd_data,
        input  err
    );

endinterface

// File: rtl/mem_arbiter_owner_fifo.sv
// Small register FIFO recording the owner of each outstanding read, in order.
module mem_arbiter_owner_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  mem_owner_t                   i_push_owner,
    input  logic                         i_pop,
    output mem_owner_t                   o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PW    = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    mem_owner_t       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Overflow and underflow are silently ignored so the count stays coherent.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, wrap-around pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= OWN_I;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_owner;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// with a starvation guard for fetch and in-order read-response routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int MAX_OUT      = DEF_MAX_OUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                             clk,
    input  logic                             rst,
    mem_arbiter_if.slave                     bus,
    output logic [$clog2(MAX_OUT+1)-1:0]     o_out_cnt,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] o_starve_cnt
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam int BW    = DW / 8;

    logic [SW-1:0]    r_starve_cnt;
    logic             r_err;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    mem_owner_t       w_head;
    mem_owner_t       w_push_owner;
    logic [CNT_W-1:0] w_count;

    logic             w_i_elig;
    logic             w_d_elig;
    logic             w_starved;
    logic             w_sel_d;
    logic             w_sel_i;
    logic             w_xfer;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;
    logic [BW-1:0]    w_sel_be;

    // Reads need a free owner slot, judged on the registered count only.
    assign w_i_elig  = bus.i_req & ~w_fifo_full;
    assign w_d_elig  = bus.d_req & (bus.d_we | ~w_fifo_full);
    assign w_starved = (r_starve_cnt >= SW'(STARVE_LIMIT));

    // D has priority unless fetch has been passed over too many times.
    assign w_sel_d = ~rst & w_d_elig & (~w_starved | ~w_i_elig);
    assign w_sel_i = ~rst & ~w_sel_d & w_i_elig;

    assign w_sel_addr  = w_sel_d ? bus.d_addr    : bus.i_addr;
    assign w_sel_wdata = w_sel_d ? bus.d_wr_data : '0;
    assign w_sel_be    = w_sel_d ? bus.d_be      : '1;

    assign bus.m_req     = w_sel_d | w_sel_i;
    assign bus.m_we      = w_sel_d & bus.d_we;
    assign bus.m_be      = w_sel_be;
    assign bus.m_addr    = w_sel_addr;
    assign bus.m_wr_data = w_sel_wdata;

    assign w_xfer    = bus.m_req & bus.m_gnt;
    assign bus.i_gnt = w_xfer & w_sel_i;
    assign bus.d_gnt = w_xfer & w_sel_d;

    // Only accepted reads expect a response and take an owner slot.
    assign w_push       = bus.i_gnt | (bus.d_gnt & ~bus.d_we);
    assign w_push_owner = w_sel_d ? OWN_D : OWN_I;

    // A response with nothing outstanding is dropped and flagged instead.
    assign w_pop        = ~rst & bus.m_rvalid & ~w_fifo_empty;
    assign bus.i_rvalid  = w_pop & (w_head == OWN_I);
    assign bus.d_rvalid  = w_pop & (w_head == OWN_D);
    assign bus.i_rd_data = bus.m_rd_data;
    assign bus.d_rd_data = bus.m_rd_data;

    assign bus.err      = r_err;
    assign o_out_cnt    = w_count;
    assign o_starve_cnt = r_starve_cnt;

    mem_arbiter_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_owner (w_push_owner),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    // Count D grants that overtook a waiting, eligible fetch; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.i_req || bus.i_gnt) begin
            r_starve_cnt <= '0;
        end else if (bus.d_gnt && w_i_elig && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Sticky flag for a response that matches no outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.m_rvalid && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule
